// File: rtl/cpu_pkg.sv
// Shared widths, end-of-program address and fetch FSM state encoding.
// No logic; constants and types only.
// Consumers: fetch_stage, pc_next_sel, fetch_stage_if, tb_fetch_stage.
package cpu_pkg;

    localparam int PC_WIDTH   = 11;
    localparam int INST_WIDTH = 9;
    localparam int CNT_WIDTH  = 16;
    localparam int DONE_PC    = 77;

    // Fixed encodings kept as plain constants so older blocks that compare
    // raw state bits keep working; the enum reuses them.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        HALT = ST_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of control, ROM and instruction-output signals of the fetch stage.
// master = fetch stage side, slave = surrounding core / ROM / testbench.
// Widths default to the shared cpu_pkg constants.
interface fetch_stage_if #(
    parameter int PC_WIDTH   = cpu_pkg::PC_WIDTH,
    parameter int INST_WIDTH = cpu_pkg::INST_WIDTH,
    parameter int CNT_WIDTH  = cpu_pkg::CNT_WIDTH
);
    logic                  start;
    logic                  stall;
    logic                  branch_en;
    logic [PC_WIDTH:0]     target;
    logic [PC_WIDTH-1:0]   rom_addr;
    logic [INST_WIDTH-1:0] rom_data;
    logic [INST_WIDTH-1:0] inst;
    logic                  inst_valid;
    logic [PC_WIDTH-1:0]   pc;
    logic                  done;
    logic [CNT_WIDTH-1:0]  retired_cnt;

    modport master (
        input  start, stall, branch_en, target, rom_data,
        output rom_addr, inst, inst_valid, pc, done, retired_cnt
    );

    modport slave (
        output start, stall, branch_en, target, rom_data,
        input  rom_addr, inst, inst_valid, pc, done, retired_cnt
    );
endinterface

// File: rtl/pc_next_sel.sv
// Next fetch-PC selection (restart, hold, branch, increment) plus halt request.
// Purely combinational, zero latency.
// stall forces hold; start overrides everything.
// Ports: state/fetch_pc/inst_valid from the stage, start/stall/branch_en/target
// from the core; pc_nxt, deliver (latch rom_data), br_taken (squash), halt_req.
module pc_next_sel #(
    parameter int PC_WIDTH = cpu_pkg::PC_WIDTH,
    parameter int DONE_PC  = cpu_pkg::DONE_PC
) (
    input  cpu_pkg::fetch_state_t state,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  inst_valid,
    input  logic                  branch_en,
    input  logic [PC_WIDTH:0]     target,
    input  logic [PC_WIDTH-1:0]   fetch_pc,
    output logic [PC_WIDTH-1:0]   pc_nxt,
    output logic                  deliver,
    output logic                  br_taken,
    output logic                  halt_req
);
    import cpu_pkg::*;

    localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(DONE_PC);

    always_comb begin
        pc_nxt   = fetch_pc;
        deliver  = 1'b0;
        br_taken = 1'b0;
        halt_req = 1'b0;
        if (start) begin
            pc_nxt = '0;
        end else begin
            unique case (state)
                // Leaving IDLE already fetches address 0, so the first
                // instruction is valid one cycle after start drops.
                IDLE: begin
                    deliver = 1'b1;
                    pc_nxt  = fetch_pc + 1'b1;
                end
                RUN: begin
                    if (!stall) begin
                        if (inst_valid && branch_en) begin
                            if (target[PC_WIDTH]) begin
                                halt_req = 1'b1;
                            end else begin
                                br_taken = 1'b1;
                                pc_nxt   = target[PC_WIDTH-1:0];
                            end
                        end else if (fetch_pc > LAST_PC) begin
                            halt_req = 1'b1;
                        end else begin
                            deliver = 1'b1;
                            pc_nxt  = fetch_pc + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the ROM address, registers inst/pc/valid.
// Latency: 1 cycle from rom_addr to inst; a taken branch costs one bubble.
// stall freezes PC and instruction register; start restarts to IDLE.
// Ports: clk, reset_n (async active-low), bus (fetch_stage_if.master).
// Optional: define FETCH_RETIRE_CNT_EN for the saturating retired_cnt counter;
// otherwise retired_cnt is tied to zero.
module fetch_stage #(
    parameter int PC_WIDTH   = cpu_pkg::PC_WIDTH,
    parameter int INST_WIDTH = cpu_pkg::INST_WIDTH,
    parameter int DONE_PC    = cpu_pkg::DONE_PC,
    parameter int CNT_WIDTH  = cpu_pkg::CNT_WIDTH
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_stage_if.master bus
);
    import cpu_pkg::*;

    fetch_state_t          state;
    logic [PC_WIDTH-1:0]   fetch_pc;
    logic [PC_WIDTH-1:0]   pc_nxt;
    logic [INST_WIDTH-1:0] inst_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic                  inst_valid_q;
    logic                  done_q;
    logic                  deliver;
    logic                  br_taken;
    logic                  halt_req;

    pc_next_sel #(
        .PC_WIDTH (PC_WIDTH),
        .DONE_PC  (DONE_PC)
    ) u_pc_next_sel (
        .state      (state),
        .start      (bus.start),
        .stall      (bus.stall),
        .inst_valid (inst_valid_q),
        .branch_en  (bus.branch_en),
        .target     (bus.target),
        .fetch_pc   (fetch_pc),
        .pc_nxt     (pc_nxt),
        .deliver    (deliver),
        .br_taken   (br_taken),
        .halt_req   (halt_req)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            fetch_pc     <= '0;
            inst_q       <= '0;
            pc_q         <= '0;
            inst_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            fetch_pc <= pc_nxt;
            if (bus.start) begin
                state        <= IDLE;
                inst_valid_q <= 1'b0;
                done_q       <= 1'b0;
            end else if (deliver) begin
                state        <= RUN;
                inst_q       <= bus.rom_data;
                pc_q         <= fetch_pc;
                inst_valid_q <= 1'b1;
            end else if (halt_req) begin
                state        <= HALT;
                done_q       <= 1'b1;
                inst_valid_q <= 1'b0;
            end else if (br_taken) begin
                // Word fetched this cycle is on the wrong path; emit a bubble.
                inst_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rom_addr   = fetch_pc;
    assign bus.inst       = inst_q;
    assign bus.pc         = pc_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.done       = done_q;

`ifdef FETCH_RETIRE_CNT_EN
    logic [CNT_WIDTH-1:0] retired_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_q <= '0;
        end else if (bus.start) begin
            retired_q <= '0;
        end else if (inst_valid_q && !bus.stall && (retired_q != '1)) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign bus.retired_cnt = retired_q;
`else
    assign bus.retired_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    logic [INST_WIDTH-1:0] rom [0:(1<<PC_WIDTH)-1];
    assign bus.rom_data = rom[bus.rom_addr];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: program-level view of the fetch stage.
    int m_mode, m_fetch, m_pc, m_inst, m_valid, m_done, m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_fetch = 0; m_pc = 0; m_inst = 0;
        m_valid = 0; m_done = 0; m_cnt = 0;
    endtask

    task automatic model_deliver();
        m_inst  = int'(rom[m_fetch]);
        m_pc    = m_fetch;
        m_valid = 1;
        m_fetch = m_fetch + 1;
    endtask

    task automatic model_halt();
        m_mode = M_HALT; m_done = 1; m_valid = 0;
    endtask

    task automatic model_step(input logic s, input logic st, input logic br,
                              input logic [PC_WIDTH:0] tg);
        if (s) m_cnt = 0;
        else if (m_valid == 1 && !st && m_cnt < 65535) m_cnt = m_cnt + 1;

        if (s) begin
            m_mode = M_IDLE; m_fetch = 0; m_valid = 0; m_done = 0;
        end else if (m_mode == M_IDLE) begin
            model_deliver();
            m_mode = M_RUN;
        end else if (m_mode == M_RUN && !st) begin
            if (m_valid == 1 && br) begin
                if (tg[PC_WIDTH]) model_halt();
                else begin m_fetch = int'(tg[PC_WIDTH-1:0]); m_valid = 0; end
            end else if (m_fetch > DONE_PC) model_halt();
            else model_deliver();
        end
    endtask

    function automatic int exp_cnt();
`ifdef FETCH_RETIRE_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic check_outputs();
        check("inst_valid", bus.inst_valid, m_valid);
        check("done", bus.done, m_done);
        if (m_valid == 1) begin
            check("pc", bus.pc, m_pc);
            check("inst", bus.inst, m_inst);
        end
        check("retired_cnt", bus.retired_cnt, exp_cnt());
    endtask

    // Starts and ends at a falling edge.
    task automatic cycle(input logic s, input logic st, input logic br,
                         input logic [PC_WIDTH:0] tg);
        bus.start = s; bus.stall = st; bus.branch_en = br; bus.target = tg;
        #1;
        check("rom_addr", bus.rom_addr, m_fetch);
        model_step(s, st, br, tg);
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic run_to_pc(input int want);
        int n;
        n = 0;
        while (!(m_valid == 1 && m_pc == want) && n < 200) begin
            cycle(1'b0, 1'b0, 1'b0, '0);
            n++;
        end
        check("reach_pc", (m_valid == 1 && m_pc == want) ? 32'd1 : 32'd0, 32'd1);
    endtask

    logic                s, st, br;
    logic [PC_WIDTH:0]   tg;
    logic [PC_WIDTH-1:0] last_pc;
    int                  n;

    initial begin
        for (int i = 0; i < (1 << PC_WIDTH); i++) rom[i] = INST_WIDTH'($urandom);
        bus.start = 1'b1; bus.stall = 1'b0; bus.branch_en = 1'b0; bus.target = '0;
        model_reset();

        // Reset state
        #12;
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_pc", bus.pc, 0);
        check("rst_inst", bus.inst, 0);
        check("rst_done", bus.done, 0);
        check("rst_rom_addr", bus.rom_addr, 0);
        check("rst_cnt", bus.retired_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: start held 3 cycles, then linear fetch
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0);
        check("t1_idle_valid", bus.inst_valid, 0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        check("t1_first_valid", bus.inst_valid, 1);
        check("t1_first_pc", bus.pc, 0);
        check("t1_first_inst", bus.inst, rom[0]);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0);

        // 2: branch at pc 5 to 20, one bubble
        run_to_pc(5);
        cycle(1'b0, 1'b0, 1'b1, 12'd20);
        check("t2_squash", bus.inst_valid, 0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        check("t2_tgt_valid", bus.inst_valid, 1);
        check("t2_tgt_pc", bus.pc, 20);
        check("t2_tgt_inst", bus.inst, rom[20]);

        // 3: stall with branch_en at pc 10
        cycle(1'b1, 1'b0, 1'b0, '0);
        run_to_pc(10);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 12'd40);
        check("t3_hold_pc", bus.pc, 10);
        check("t3_hold_inst", bus.inst, rom[10]);
        check("t3_hold_addr", bus.rom_addr, 11);
        cycle(1'b0, 1'b0, 1'b0, '0);
        check("t3_resume_pc", bus.pc, 11);

        // 4: linear run to end of program
        cycle(1'b1, 1'b0, 1'b0, '0);
        last_pc = '0;
        n = 0;
        while (!bus.done && n < 200) begin
            cycle(1'b0, 1'b0, 1'b0, '0);
            if (bus.inst_valid) last_pc = bus.pc;
            n++;
        end
        check("t4_done", bus.done, 1);
        check("t4_last_pc", last_pc, DONE_PC);
        check("t4_valid", bus.inst_valid, 0);
`ifdef FETCH_RETIRE_CNT_EN
        check("t4_cnt", bus.retired_cnt, DONE_PC + 1);
`endif
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 12'd3);
        check("t4_still_done", bus.done, 1);

        // 5: out-of-range branch target halts, start recovers
        cycle(1'b1, 1'b0, 1'b0, '0);
        check("t5_clr_done", bus.done, 0);
        check("t5_addr0", bus.rom_addr, 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b1, 12'h800);
        check("t5_oor_done", bus.done, 1);
        check("t5_oor_valid", bus.inst_valid, 0);
        cycle(1'b1, 1'b0, 1'b0, '0);
        check("t5_restart_done", bus.done, 0);
        check("t5_restart_addr", bus.rom_addr, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            s  = (m_mode == M_HALT) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 149) == 0);
            st = ($urandom_range(0, 4) == 0);
            br = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 15) == 0) tg = {1'b1, PC_WIDTH'($urandom)};
            else tg = {1'b0, PC_WIDTH'($urandom_range(0, 90))};
            cycle(s, st, br, tg);
        end

        // 6: asynchronous reset between edges mid-run
        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, '0);
        bus.stall = 1'b1; bus.branch_en = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_valid", bus.inst_valid, 0);
        check("t6_pc", bus.pc, 0);
        check("t6_inst", bus.inst, 0);
        check("t6_done", bus.done, 0);
        check("t6_addr", bus.rom_addr, 0);
        check("t6_cnt", bus.retired_cnt, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        check("t6_after_pc", bus.pc, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
